cityscapes_color_decoder: RTL and testbench

CITYSCAPES_COLOR_DECODER -- requirements
Module: cityscapes_color_decoder

---
 rtl/cityscapes_pkg.sv | 48 ++++
 rtl/cityscapes_palette_lookup.sv | 22 ++
 rtl/cityscapes_color_decoder.sv | 172 +++++++++++++++++
 tb/tb_cityscapes_color_decoder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cityscapes_pkg.sv
// Shared Cityscapes palette and frame-tracking types, used by both the colour
// decoder and the visualization mapper so the two can never drift apart.
package cityscapes_pkg;

    localparam int NUM_CLASSES = 20;

    typedef struct packed {
        logic [23:0] rgb;
        logic [7:0]  train_id;
        logic [7:0]  label_id;
    } palette_entry_t;

    typedef struct packed {
        logic [7:0] class_id;
        logic [7:0] label_id;
        logic       hit;
    } lookup_result_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } frame_state_e;

    // Entry index equals train ID; every RGB value is unique.
    localparam palette_entry_t [0:NUM_CLASSES-1] PALETTE = '{
        '{24'h000000, 8'd0,  8'd0 },
        '{24'h808080, 8'd1,  8'd7 },
        '{24'hC08080, 8'd2,  8'd8 },
        '{24'h800080, 8'd3,  8'd11},
        '{24'hA06060, 8'd4,  8'd12},
        '{24'hA08060, 8'd5,  8'd13},
        '{24'hA0A060, 8'd6,  8'd17},
        '{24'hE0E000, 8'd7,  8'd19},
        '{24'hE06000, 8'd8,  8'd20},
        '{24'h008000, 8'd9,  8'd21},
        '{24'h608000, 8'd10, 8'd22},
        '{24'h000080, 8'd11, 8'd23},
        '{24'hE00000, 8'd12, 8'd24},
        '{24'hC00040, 8'd13, 8'd25},
        '{24'h0000E0, 8'd14, 8'd26},
        '{24'h0080C0, 8'd15, 8'd27},
        '{24'h008080, 8'd16, 8'd28},
        '{24'h004080, 8'd17, 8'd31},
        '{24'h800000, 8'd18, 8'd32},
        '{24'h804000, 8'd19, 8'd33}
    };

endpackage

// File: rtl/cityscapes_palette_lookup.sv
// Combinational RGB -> (train ID, label ID, hit) lookup against the shared palette.
// Unknown colours return all zeros with hit cleared.
module cityscapes_palette_lookup
    import cityscapes_pkg::*;
(
    input  logic [23:0]    rgb_i,
    output lookup_result_t result_o
);

    always_comb begin
        // NOTE: default every output before the search so no path leaves it unassigned (no latch).
        result_o = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (rgb_i == PALETTE[i].rgb) begin
                result_o.class_id = PALETTE[i].train_id;
                result_o.label_id = PALETTE[i].label_id;
                result_o.hit      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cityscapes_color_decoder.sv
// Two-stage streaming decoder from Cityscapes visualization colours back to IDs,
// with per-frame pixel/miss statistics and a frame-activity FSM.
module cityscapes_color_decoder
    import cityscapes_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_r,
    input  logic [7:0]       s_g,
    input  logic [7:0]       s_b,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_class_id,
    output logic [7:0]       m_label_id,
    output logic             m_hit,
    output logic             m_last,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_pixels,
    output logic [CNT_W-1:0] frame_misses,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic           rst_done_q;

    logic           s1_valid_q, s1_valid_d;
    logic [23:0]    s1_rgb_q,   s1_rgb_d;
    logic           s1_last_q,  s1_last_d;

    logic           m_valid_q,  m_valid_d;
    lookup_result_t m_res_q,    m_res_d;
    logic           m_last_q,   m_last_d;

    logic [CNT_W-1:0] live_pix_q,   live_pix_d;
    logic [CNT_W-1:0] live_miss_q,  live_miss_d;
    logic [CNT_W-1:0] frame_pix_q,  frame_pix_d;
    logic [CNT_W-1:0] frame_miss_q, frame_miss_d;
    logic             frame_done_q, frame_done_d;

    frame_state_e   state_q;

    lookup_result_t lookup_res;
    logic           s2_adv;
    logic           s1_free;
    logic           in_xfer;
    logic           out_xfer;
    logic           frame_end;

    cityscapes_palette_lookup u_lookup (
        .rgb_i    (s1_rgb_q),
        .result_o (lookup_res)
    );

    // Output stage moves when empty or being drained; stage 1 then can refill.
    assign s2_adv    = !m_valid_q || m_ready;
    assign s1_free   = !s1_valid_q || s2_adv;
    assign s_ready   = rst_done_q && s1_free;
    assign in_xfer   = s_valid && s_ready;
    assign out_xfer  = m_valid_q && m_ready;
    assign frame_end = out_xfer && m_last_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_rgb_d   = s1_rgb_q;
        s1_last_d  = s1_last_q;
        m_valid_d  = m_valid_q;
        m_res_d    = m_res_q;
        m_last_d   = m_last_q;

        if (s1_free) begin
            s1_valid_d = in_xfer;
            if (in_xfer) begin
                s1_rgb_d  = {s_r, s_g, s_b};
                s1_last_d = s_last;
            end
        end

        if (s2_adv) begin
            m_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                m_res_d  = lookup_res;
                m_last_d = s1_last_q;
            end
        end
    end

    always_comb begin
        live_pix_d   = live_pix_q;
        live_miss_d  = live_miss_q;
        frame_pix_d  = frame_pix_q;
        frame_miss_d = frame_miss_q;
        frame_done_d = 1'b0;

        if (out_xfer) begin
            live_pix_d  = sat_inc(live_pix_q);
            live_miss_d = m_res_q.hit ? live_miss_q : sat_inc(live_miss_q);
            // The closing pixel is folded into the published totals, then the live counts restart.
            if (m_last_q) begin
                frame_pix_d  = live_pix_d;
                frame_miss_d = live_miss_d;
                frame_done_d = 1'b1;
                live_pix_d   = '0;
                live_miss_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_rgb_q     <= '0;
            s1_last_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_res_q      <= '0;
            m_last_q     <= 1'b0;
            live_pix_q   <= '0;
            live_miss_q  <= '0;
            frame_pix_q  <= '0;
            frame_miss_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rst_done_q   <= 1'b1;
            s1_valid_q   <= s1_valid_d;
            s1_rgb_q     <= s1_rgb_d;
            s1_last_q    <= s1_last_d;
            m_valid_q    <= m_valid_d;
            m_res_q      <= m_res_d;
            m_last_q     <= m_last_d;
            live_pix_q   <= live_pix_d;
            live_miss_q  <= live_miss_d;
            frame_pix_q  <= frame_pix_d;
            frame_miss_q <= frame_miss_d;
            frame_done_q <= frame_done_d;
        end
    end

    // A frame closes only if nothing of a following frame is already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (in_xfer) state_q <= ST_ACTIVE;
                ST_ACTIVE: if (frame_end && !s1_valid_q && !in_xfer) state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy         = (state_q == ST_ACTIVE);
    assign m_valid      = m_valid_q;
    assign m_class_id   = m_res_q.class_id;
    assign m_label_id   = m_res_q.label_id;
    assign m_hit        = m_res_q.hit;
    assign m_last       = m_last_q;
    assign frame_done   = frame_done_q;
    assign frame_pixels = frame_pix_q;
    assign frame_misses = frame_miss_q;

endmodule

// File: tb/tb_cityscapes_color_decoder.sv
// Self-checking bench: a queue-based reference model of the decoder, checked every
// cycle on the falling edge, plus directed frames and a randomized back-pressure frame.
`timescale 1ns/1ps
module tb_cityscapes_color_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_r = 8'd0, s_g = 8'd0, s_b = 8'd0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b1;

    logic        s_ready, m_valid, m_hit, m_last, frame_done, busy;
    logic [7:0]  m_class_id, m_label_id;
    logic [23:0] frame_pixels, frame_misses;

    logic        s4_ready, m4_valid, m4_hit, m4_last, fd4, busy4;
    logic [7:0]  m4_class_id, m4_label_id;
    logic [3:0]  fp4, fm4;

    always #5 clk = ~clk;

    cityscapes_color_decoder #(.CNT_W(24)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_g(s_g), .s_b(s_b), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_class_id(m_class_id), .m_label_id(m_label_id),
        .m_hit(m_hit), .m_last(m_last),
        .frame_done(frame_done), .frame_pixels(frame_pixels), .frame_misses(frame_misses), .busy(busy)
    );

    cityscapes_color_decoder #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s4_ready), .s_r(s_r), .s_g(s_g), .s_b(s_b), .s_last(s_last),
        .m_valid(m4_valid), .m_ready(m_ready), .m_class_id(m4_class_id), .m_label_id(m4_label_id),
        .m_hit(m4_hit), .m_last(m4_last),
        .frame_done(fd4), .frame_pixels(fp4), .frame_misses(fm4), .busy(busy4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference palette; train ID is the array index.
    bit [23:0] ref_rgb [20] = '{24'h000000, 24'h808080, 24'hC08080, 24'h800080, 24'hA06060,
                                24'hA08060, 24'hA0A060, 24'hE0E000, 24'hE06000, 24'h008000,
                                24'h608000, 24'h000080, 24'hE00000, 24'hC00040, 24'h0000E0,
                                24'h0080C0, 24'h008080, 24'h004080, 24'h800000, 24'h804000};
    int ref_label [20] = '{0, 7, 8, 11, 12, 13, 17, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 31, 32, 33};

    typedef struct {
        logic [7:0] cls;
        logic [7:0] lbl;
        logic       hit;
        logic       last;
    } exp_t;

    function automatic exp_t model_decode(input logic [23:0] rgb, input logic last);
        exp_t r;
        r.cls = 8'd0; r.lbl = 8'd0; r.hit = 1'b0; r.last = last;
        for (int i = 0; i < 20; i++) begin
            if (ref_rgb[i] == rgb) begin
                r.cls = 8'(i);
                r.lbl = 8'(ref_label[i]);
                r.hit = 1'b1;
            end
        end
        return r;
    endfunction

    // Reference model state
    exp_t exp_q [$];
    exp_t e_cur;
    int   cyc = 0;
    int   mdl_pix = 0, mdl_miss = 0;
    int   mdl_fp = 0, mdl_fm = 0, mdl_fp4 = 0, mdl_fm4 = 0;
    logic fd_pend = 1'b0;
    logic exp_busy = 1'b0;
    int   first_out_cyc = 0, frame_span = 0;
    int   done_count = 0;
    logic held = 1'b0;
    logic [17:0] hold_val = '0;
    int   hold_checks = 0;
    logic track_busy = 1'b0;
    int   busy_drops = 0;
    logic rand_ready = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check("reset_outputs",
                  64'({s_ready, m_valid, m_class_id, m_label_id, m_hit, m_last, frame_done, busy}), 64'd0);
            check("reset_counts", 64'({frame_pixels, frame_misses, fp4, fm4}), 64'd0);
            exp_q.delete();
            mdl_pix = 0; mdl_miss = 0;
            mdl_fp = 0; mdl_fm = 0; mdl_fp4 = 0; mdl_fm4 = 0;
            fd_pend = 1'b0; exp_busy = 1'b0; held = 1'b0;
        end else begin
            check("frame_done", 64'(frame_done), 64'(fd_pend));
            check("frame_pixels", 64'(frame_pixels), 64'(mdl_fp));
            check("frame_misses", 64'(frame_misses), 64'(mdl_fm));
            check("frame_pixels_w4", 64'(fp4), 64'(mdl_fp4));
            check("frame_misses_w4", 64'(fm4), 64'(mdl_fm4));
            check("busy", 64'(busy), 64'(exp_busy));
            if (frame_done) done_count++;
            if (track_busy && !busy) busy_drops++;
            if (held) begin
                hold_checks++;
                check("stall_hold", 64'({m_valid, m_class_id, m_label_id, m_hit}), 64'(hold_val));
            end
            fd_pend = 1'b0;

            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(m_valid), 64'd0);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("out_pixel", 64'({m_class_id, m_label_id, m_hit, m_last}),
                          64'({e_cur.cls, e_cur.lbl, e_cur.hit, e_cur.last}));
                    if (mdl_pix == 0) first_out_cyc = cyc;
                    mdl_pix++;
                    if (!e_cur.hit) mdl_miss++;
                    if (e_cur.last) begin
                        mdl_fp  = mdl_pix;
                        mdl_fm  = mdl_miss;
                        mdl_fp4 = (mdl_pix > 15) ? 15 : mdl_pix;
                        mdl_fm4 = (mdl_miss > 15) ? 15 : mdl_miss;
                        frame_span = cyc - first_out_cyc;
                        fd_pend = 1'b1;
                        mdl_pix = 0;
                        mdl_miss = 0;
                    end
                end
            end

            if (s_valid && s_ready) begin
                exp_q.push_back(model_decode({s_r, s_g, s_b}, s_last));
                exp_busy = 1'b1;
            end else if (fd_pend && exp_q.size() == 0) begin
                exp_busy = 1'b0;
            end

            held = m_valid && !m_ready;
            hold_val = {m_valid, m_class_id, m_label_id, m_hit};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [23:0] rgb, input logic last);
        logic acc;
        acc = 1'b0;
        s_valid = 1'b1;
        {s_r, s_g, s_b} = rgb;
        s_last = last;
        for (int t = 0; t < 2000 && !acc; t++) begin
            @(negedge clk);
            acc = s_ready;
            tick();
        end
        if (!acc) check("send_timeout", 64'(acc), 64'd1);
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_done(output int fp, output int fm, output int p4, output int m4);
        logic seen;
        seen = 1'b0;
        fp = -1; fm = -1; p4 = -1; m4 = -1;
        for (int t = 0; t < 10000 && !seen; t++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                fp = int'(frame_pixels); fm = int'(frame_misses);
                p4 = int'(fp4); m4 = int'(fm4);
            end
            tick();
        end
        if (!seen) check("frame_done_timeout", 64'(seen), 64'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t pin;
        int fp, fm, p4, m4, start, d0;
        logic [23:0] rgb;

        pin = model_decode(24'hE0E000, 1'b0);
        check("model_pin_e0e000", 64'({pin.cls, pin.lbl, pin.hit}), 64'({8'd7, 8'd19, 1'b1}));
        pin = model_decode(24'h808081, 1'b0);
        check("model_pin_miss", 64'({pin.cls, pin.lbl, pin.hit}), 64'd0);
        pin = model_decode(24'h804000, 1'b0);
        check("model_pin_804000", 64'({pin.cls, pin.lbl, pin.hit}), 64'({8'd19, 8'd33, 1'b1}));

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", 64'(s_ready), 64'd1);

        // Latency: first pixel appears two cycles after the accepting cycle
        send(24'h808080, 1'b1);
        check("latency_cycle1", 64'(m_valid), 64'd0);
        tick();
        check("latency_cycle2", 64'({m_valid, m_class_id, m_label_id, m_hit}), 64'({1'b1, 8'd1, 8'd7, 1'b1}));
        wait_done(fp, fm, p4, m4);
        check("single_frame_pixels", 64'(fp), 64'd1);

        // Whole palette back to back
        repeat (3) tick();
        d0 = done_count;
        start = cyc;
        for (int i = 0; i < 20; i++) send(ref_rgb[i], i == 19);
        check("palette_accept_cycles", 64'(cyc - start), 64'd20);
        wait_done(fp, fm, p4, m4);
        repeat (4) tick();
        check("palette_pixels", 64'(fp), 64'd20);
        check("palette_misses", 64'(fm), 64'd0);
        check("palette_out_span", 64'(frame_span), 64'd19);
        check("palette_done_pulses", 64'(done_count - d0), 64'd1);

        // Near-miss then black
        send(24'h808081, 1'b0);
        send(24'h000000, 1'b1);
        wait_done(fp, fm, p4, m4);
        check("nearmiss_pixels", 64'(fp), 64'd2);
        check("nearmiss_misses", 64'(fm), 64'd1);

        // 1000-pixel frame under random back-pressure
        hold_checks = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 0) rgb = ref_rgb[$urandom_range(0, 19)];
            else rgb = 24'($urandom);
            if ($urandom_range(0, 7) == 0) tick();
            send(rgb, i == 999);
        end
        wait_done(fp, fm, p4, m4);
        rand_ready = 1'b0;
        m_ready = 1'b1;
        check("random_frame_pixels", 64'(fp), 64'd1000);
        check("random_stalls_seen", 64'(hold_checks > 0), 64'd1);

        // Two frames without a gap
        repeat (3) tick();
        d0 = done_count;
        busy_drops = 0;
        send(ref_rgb[3], 1'b0);
        track_busy = 1'b1;
        send(ref_rgb[4], 1'b0);
        send(24'h123456, 1'b1);
        send(ref_rgb[5], 1'b0);
        send(ref_rgb[6], 1'b1);
        wait_done(fp, fm, p4, m4);
        track_busy = 1'b0;
        check("frame_a_pixels", 64'(fp), 64'd3);
        check("frame_a_misses", 64'(fm), 64'd1);
        wait_done(fp, fm, p4, m4);
        check("frame_b_pixels", 64'(fp), 64'd2);
        check("busy_between_frames", 64'(busy_drops), 64'd0);
        check("two_frame_done_pulses", 64'(done_count - d0), 64'd2);

        // Saturation of the narrow counters
        for (int i = 0; i < 20; i++) send(24'h010203 + 24'(i), i == 19);
        wait_done(fp, fm, p4, m4);
        check("sat_pixels_w4", 64'(p4), 64'd15);
        check("sat_misses_w4", 64'(m4), 64'd15);
        check("sat_pixels_w24", 64'(fp), 64'd20);

        // Reset with two pixels stuck in the pipeline
        repeat (3) tick();
        m_ready = 1'b0;
        send(ref_rgb[7], 1'b0);
        send(ref_rgb[8], 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 64'({m_valid, busy, s_ready}), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        tick();
        check("ready_after_midreset", 64'(s_ready), 64'd1);
        send(ref_rgb[9], 1'b0);
        send(24'hFFFFFF, 1'b0);
        send(ref_rgb[10], 1'b1);
        wait_done(fp, fm, p4, m4);
        check("post_reset_pixels", 64'(fp), 64'd3);
        check("post_reset_misses", 64'(fm), 64'd1);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
